// File: rtl/video_ds_pkg.sv
// Shared definitions for the video downscaler: mode encodings, block-size
// lookup and the extra accumulator bits each filter needs.
package video_ds_pkg;

    typedef enum logic [2:0] {
        DS_BYPASS = 3'd0,
        DS_SUB2   = 3'd1,
        DS_SUB3   = 3'd2,
        DS_AVG2   = 3'd3,
        DS_AVG3   = 3'd4,
        DS_CROSS3 = 3'd5
    } ds_mode_e;

    // Bits added on top of WIDTH by each accumulator (2x2 sum, 3x3 sum, cross sum).
    localparam int SUM2_EXTRA  = 2;
    localparam int SUM9_EXTRA  = 4;
    localparam int CROSS_EXTRA = 3;

    // Block edge length N; bypass and illegal encodings act as 1x1.
    function automatic int block_n(input int mode);
        if (mode == int'(DS_SUB2) || mode == int'(DS_AVG2))
            return 2;
        if (mode == int'(DS_SUB3) || mode == int'(DS_AVG3) || mode == int'(DS_CROSS3))
            return 3;
        return 1;
    endfunction

endpackage

// File: rtl/ds_line_buf.sv
// One-line delay: read the previous line's pixel at addr, then overwrite it
// with the current one in the same cycle.
module ds_line_buf #(
    parameter int DW    = 30,
    parameter int DEPTH = 10,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the storage has no reset; every entry is rewritten during a line
    // before any block of the frame reads it back.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= din;
    end

    assign dout = mem[addr];

endmodule

// File: rtl/video_downscaler.sv
// Streaming 2-D downscaler: builds an NxN window from line buffers plus a
// per-row shift register and emits one filtered pixel per block, 1 clk later.
module video_downscaler
    import video_ds_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int HACT    = 10,
    parameter bit is_gray = 1'b0,
    parameter int ds_mode = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic [WIDTH-1:0] i_r_data,
    input  logic [WIDTH-1:0] i_g_data,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_de,
    output logic [WIDTH-1:0] o_r_data,
    output logic [WIDTH-1:0] o_g_data,
    output logic [WIDTH-1:0] o_b_data
);

    localparam int NBLK  = block_n(ds_mode);
    localparam int NCH   = is_gray ? 1 : 3;
    localparam int CW    = NCH * WIDTH;
    localparam int AW    = (HACT > 1) ? $clog2(HACT) : 1;
    localparam int SW    = WIDTH + SUM9_EXTRA;
    localparam int G_OFS = is_gray ? 0 : WIDTH;
    localparam int B_OFS = is_gray ? 0 : 2 * WIDTH;
    localparam ds_mode_e MODE = (ds_mode >= 1 && ds_mode <= 5) ? ds_mode_e'(3'(ds_mode)) : DS_BYPASS;

    logic [AW-1:0]    col;
    logic [11:0]      ln;
    logic             de_d;
    logic             frame_ok;
    logic [CW-1:0]    px_in;
    logic [CW-1:0]    row_in [3];
    logic [CW-1:0]    hist   [3][2];
    logic [WIDTH-1:0] win    [3][3];
    logic [SW-1:0]    acc;
    logic [CW-1:0]    res;
    logic             blk_end;
    logic             de_next;

    if (is_gray) begin : g_px_gray
        assign px_in = i_r_data;
    end else begin : g_px_rgb
        assign px_in = {i_b_data, i_g_data, i_r_data};
    end

    // Row 2 is the live input; rows 1 and 0 are one and two lines above it.
    assign row_in[2] = px_in;
    for (genvar i = 0; i < 2; i++) begin : g_lb
        if (i < NBLK - 1) begin : g_on
            ds_line_buf #(.DW(CW), .DEPTH(HACT), .AW(AW)) u_lb (
                .clk  (clk),
                .we   (i_de),
                .addr (col),
                .din  (row_in[2-i]),
                .dout (row_in[1-i])
            );
        end else begin : g_off
            assign row_in[1-i] = '0;
        end
    end

    // rstn is active-high here: 1 holds the block in reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rstn) begin
            col      <= '0;
            ln       <= '0;
            de_d     <= 1'b0;
            frame_ok <= 1'b0;
        end else begin
            de_d <= i_de;
            col  <= i_de ? col + 1'b1 : '0;
            if (i_vsync)
                ln <= '0;
            else if (de_d && !i_de)
                ln <= ln + 1'b1;
            if (i_vsync)
                frame_ok <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int r = 0; r < 3; r++) begin
                hist[r][0] <= '0;
                hist[r][1] <= '0;
            end
        end else if (i_de) begin
            for (int r = 0; r < 3; r++) begin
                hist[r][0] <= row_in[r];
                hist[r][1] <= hist[r][0];
            end
        end
    end

    assign blk_end = (int'(col) % NBLK == NBLK - 1) && (int'(ln) % NBLK == NBLK - 1);
    assign de_next = (MODE == DS_BYPASS) ? i_de : (i_de && frame_ok && blk_end);

    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        res = '0;
        acc = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                win[r][c] = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int r = 0; r < 3; r++) begin
                win[r][2] = row_in[r][ch*WIDTH +: WIDTH];
                win[r][1] = hist[r][0][ch*WIDTH +: WIDTH];
                win[r][0] = hist[r][1][ch*WIDTH +: WIDTH];
            end
            acc = '0;
            case (MODE)
                DS_AVG2: begin
                    for (int r = 1; r < 3; r++)
                        for (int c = 1; c < 3; c++)
                            acc = acc + SW'(win[r][c]);
                    res[ch*WIDTH +: WIDTH] = WIDTH'(acc >> SUM2_EXTRA);
                end
                DS_AVG3: begin
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            acc = acc + SW'(win[r][c]);
                    res[ch*WIDTH +: WIDTH] = WIDTH'(acc / SW'(9));
                end
                DS_CROSS3: begin
                    acc = (SW'(win[1][1]) << 2) + SW'(win[0][1]) + SW'(win[2][1])
                        + SW'(win[1][0]) + SW'(win[1][2]);
                    res[ch*WIDTH +: WIDTH] = WIDTH'(acc >> CROSS_EXTRA);
                end
                default: res[ch*WIDTH +: WIDTH] = win[2][2];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            o_vsync  <= 1'b0;
            o_hsync  <= 1'b0;
            o_de     <= 1'b0;
            o_r_data <= '0;
            o_g_data <= '0;
            o_b_data <= '0;
        end else begin
            o_vsync  <= i_vsync;
            o_hsync  <= i_hsync;
            o_de     <= de_next;
            o_r_data <= de_next ? res[0 +: WIDTH]     : '0;
            o_g_data <= de_next ? res[G_OFS +: WIDTH] : '0;
            o_b_data <= de_next ? res[B_OFS +: WIDTH] : '0;
        end
    end

endmodule

// File: tb/tb_video_downscaler.sv
// Drives one stimulus stream into every mode variant of the downscaler and
// compares each output cycle against a frame-array reference model.
module tb_video_downscaler;

    localparam int W    = 10;
    localparam int HACT = 10;
    localparam int NI   = 8;
    localparam int MODES [NI] = '{0, 1, 2, 3, 4, 5, 3, 7};
    localparam bit GRAYS [NI] = '{0, 0, 0, 0, 0, 0, 1, 0};
    localparam int EXP_CNT [NI] = '{40, 10, 3, 10, 3, 3, 10, 40};

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         i_vsync = 1'b0, i_hsync = 1'b0, i_de = 1'b0;
    logic [W-1:0] i_r = '0, i_g = '0, i_b = '0;

    logic         o_vs [NI];
    logic         o_hs [NI];
    logic         o_de [NI];
    logic [W-1:0] o_r  [NI];
    logic [W-1:0] o_g  [NI];
    logic [W-1:0] o_b  [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        video_downscaler #(.WIDTH(W), .HACT(HACT), .is_gray(GRAYS[k]), .ds_mode(MODES[k])) u_dut (
            .clk      (clk),
            .rstn     (rstn),
            .i_vsync  (i_vsync),
            .i_hsync  (i_hsync),
            .i_de     (i_de),
            .i_r_data (i_r),
            .i_g_data (i_g),
            .i_b_data (i_b),
            .o_vsync  (o_vs[k]),
            .o_hsync  (o_hs[k]),
            .o_de     (o_de[k]),
            .o_r_data (o_r[k]),
            .o_g_data (o_g[k]),
            .o_b_data (o_b[k])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference state: pixels of the current frame by (line, column), and
    // whether a vsync has been seen since reset.
    logic [W-1:0] pix [3][8][HACT];
    bit           fok_m = 1'b0;

    bit           cap_on = 1'b0;
    bit           post_rst_on = 1'b0;
    int           cnt [NI];
    int           post_cnt [NI];
    logic [W-1:0] qr [NI][$];
    logic [W-1:0] qg [NI][$];

    function automatic logic [3*W:0] model(input int k, input bit de, input int l, input int c);
        int m, n, s;
        logic [W-1:0] v [3];
        m = MODES[k];
        n = (m == 1 || m == 3) ? 2 : (m == 2 || m == 4 || m == 5) ? 3 : 1;
        if (n == 1) begin
            if (!de) return '0;
            for (int ch = 0; ch < 3; ch++) v[ch] = pix[ch][l][c];
        end else begin
            if (!(de && fok_m && (c % n == n - 1) && (l % n == n - 1))) return '0;
            for (int ch = 0; ch < 3; ch++) begin
                s = 0;
                if (m == 1 || m == 2) begin
                    s = int'(pix[ch][l][c]);
                end else if (m == 3 || m == 4) begin
                    for (int dl = 0; dl < n; dl++)
                        for (int dc = 0; dc < n; dc++)
                            s += int'(pix[ch][l-dl][c-dc]);
                    s = (m == 3) ? s / 4 : s / 9;
                end else begin
                    s = (4 * int'(pix[ch][l-1][c-1]) + int'(pix[ch][l-2][c-1]) + int'(pix[ch][l][c-1])
                         + int'(pix[ch][l-1][c-2]) + int'(pix[ch][l-1][c])) / 8;
                end
                v[ch] = W'(s);
            end
        end
        if (GRAYS[k]) return {1'b1, v[0], v[0], v[0]};
        return {1'b1, v[0], v[1], v[2]};
    endfunction

    task automatic step(input bit rst, input bit vs, input bit hs, input bit de,
                        input int l, input int c, input logic [W-1:0] r, g, b);
        logic [32:0] exp [NI];
        @(negedge clk);
        rstn = rst; i_vsync = vs; i_hsync = hs; i_de = de;
        i_r = r; i_g = g; i_b = b;
        if (de) begin
            pix[0][l][c] = r;
            pix[1][l][c] = g;
            pix[2][l][c] = b;
        end
        for (int k = 0; k < NI; k++)
            exp[k] = rst ? 33'd0 : {vs, hs, model(k, de, l, c)};
        if (rst) fok_m = 1'b0;
        else if (vs) fok_m = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d_mode%0d_out", k, MODES[k]),
                  {31'd0, o_vs[k], o_hs[k], o_de[k], o_r[k], o_g[k], o_b[k]},
                  {31'd0, exp[k]});
            if (cap_on && o_de[k]) begin
                cnt[k]++;
                qr[k].push_back(o_r[k]);
                qg[k].push_back(o_g[k]);
            end
            if (post_rst_on && o_de[k]) post_cnt[k]++;
        end
    endtask

    // Frame: HSW1/HBP2/HACT10/HFP2 per line, VSW1/VBP1/VACT/VFP1 (no VFP when
    // truncated). kind 0 = ramp pattern, 1 = ramp R with random G/B, 2 = random.
    task automatic run_frame(input int vact, input int kind, input int rst_line);
        int lines;
        lines = 2 + vact + ((vact == 4) ? 1 : 0);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < 15; x++) begin
                bit de, rst;
                int l, c;
                logic [W-1:0] r, g, b;
                de  = (y >= 2) && (y < 2 + vact) && (x >= 3) && (x < 13);
                rst = (y == rst_line) && (x >= 6) && (x < 9);
                l = y - 2;
                c = x - 3;
                r = '0; g = '0; b = '0;
                if (de) begin
                    if (kind == 2) r = W'($urandom);
                    else           r = W'(16 * l + c);
                    if (kind == 0) begin
                        g = r + 1'b1;
                        b = r + 2'd2;
                    end else begin
                        g = W'($urandom);
                        b = W'($urandom);
                    end
                end
                post_rst_on = (rst_line >= 0) && ((y > rst_line) || (y == rst_line && x >= 9));
                step(rst, (y < 1), (x == 0), de, l, c, r, g, b);
            end
        end
        post_rst_on = 1'b0;
    endtask

    task automatic verify_capture(input string tag);
        int e1 [5];
        int e3 [5];
        int e9 [3];
        e1 = '{17, 19, 21, 23, 25};
        e3 = '{8, 10, 12, 14, 16};
        e9 = '{17, 20, 23};
        for (int k = 0; k < NI; k++)
            check($sformatf("%s_u%0d_count", tag, k), 64'(cnt[k]), 64'(EXP_CNT[k]));
        if (cnt[0] == 40) begin
            check({tag, "_m0_first"}, 64'(qr[0][0]), 64'd0);
            check({tag, "_m0_last"},  64'(qr[0][39]), 64'd57);
        end
        if (cnt[1] == 10) begin
            for (int i = 0; i < 5; i++)
                check($sformatf("%s_m1_ln1_%0d", tag, i), 64'(qr[1][i]), 64'(e1[i]));
            check({tag, "_m1_ln3_first"}, 64'(qr[1][5]), 64'd49);
            check({tag, "_m1_ln3_last"},  64'(qr[1][9]), 64'd57);
        end
        if (cnt[2] == 3)
            for (int i = 0; i < 3; i++)
                check($sformatf("%s_m2_%0d", tag, i), 64'(qr[2][i]), 64'(34 + 3 * i));
        if (cnt[3] == 10) begin
            for (int i = 0; i < 5; i++)
                check($sformatf("%s_m3_%0d", tag, i), 64'(qr[3][i]), 64'(e3[i]));
            check({tag, "_m3_g_first"},   64'(qg[3][0]), 64'd9);
            check({tag, "_m3_ln3_first"}, 64'(qr[3][5]), 64'd40);
        end
        if (cnt[4] == 3)
            for (int i = 0; i < 3; i++)
                check($sformatf("%s_m4_%0d", tag, i), 64'(qr[4][i]), 64'(e9[i]));
        if (cnt[5] == 3)
            for (int i = 0; i < 3; i++)
                check($sformatf("%s_m5_%0d", tag, i), 64'(qr[5][i]), 64'(e9[i]));
        if (cnt[6] == 10) begin
            check({tag, "_gray_r_first"}, 64'(qr[6][0]), 64'd8);
            check({tag, "_gray_g_first"}, 64'(qg[6][0]), 64'd8);
        end
        if (cnt[7] == 40)
            check({tag, "_illegal_bypass_last"}, 64'(qr[7][39]), 64'd57);
        for (int k = 0; k < NI; k++) begin
            cnt[k] = 0;
            qr[k].delete();
            qg[k].delete();
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            cnt[k] = 0;
            post_cnt[k] = 0;
        end
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0, '0, '0);

        cap_on = 1'b1;
        run_frame(4, 0, -1);
        cap_on = 1'b0;
        verify_capture("f0");

        run_frame(4, 1, -1);
        run_frame(2, 2, -1);
        run_frame(4, 2, -1);
        run_frame(4, 2, -1);

        run_frame(4, 2, 3);
        for (int k = 1; k < 7; k++)
            check($sformatf("post_rst_u%0d_no_de", k), 64'(post_cnt[k]), 64'd0);

        cap_on = 1'b1;
        run_frame(4, 0, -1);
        cap_on = 1'b0;
        verify_capture("after_rst");

        run_frame(4, 1, -1);
        run_frame(4, 2, -1);
        run_frame(4, 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
